// File: rtl/pwm_pkg.sv
// Shared PWM definitions: sample width, offset-binary conversion constant,
// encoder state encoding and the sample-to-duty mapping function.
package pwm_pkg;

    localparam int          SAMPLE_W   = 16;
    localparam logic [15:0] OFFSET_XOR = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

    // Signed sample -> offset binary, keeping the top cnt_w bits as the duty.
    // -32768 maps to 0 and +32767 to 2**cnt_w-1, so full-high never occurs.
    function automatic logic [SAMPLE_W-1:0] duty_map(input logic [SAMPLE_W-1:0] sample,
                                                     input int cnt_w);
        logic [SAMPLE_W-1:0] offset;
        offset = sample ^ OFFSET_XOR;
        return offset >> (SAMPLE_W - cnt_w);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter. Counts while run is high, wraps modulo
// 2**CNT_W, and is forced to zero by a synchronous clear.
module pwm_period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             at_zero,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise advance while running.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_zero = (count_q == '0);
    assign at_max  = (count_q == '1);

endmodule

// File: rtl/pwm_encoder.sv
// PWM encoder: turns a stream of signed 16-bit samples into a single-bit PWM
// waveform, one sample per 2**CNT_W-clock period. A one-entry holding register
// decouples the sample stream from the period boundaries so that duty changes
// are only ever applied at counter==0.
//
// Handshake: a sample transfers on a rising clock edge where data_valid and
// data_ready are both high. data_ready is registered; it is high exactly when
// the holding register is empty and the encoder is not draining. The source
// must hold data_in stable while data_valid is high and not yet accepted.
module pwm_encoder
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                pwm_out,
    output logic                period_start,
    output logic                underrun,
    output logic                busy
);

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             period_start_q, period_start_d;
    logic             underrun_q, underrun_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [CNT_W-1:0] count;
    logic             at_zero;
    logic             at_max;
    logic             cnt_run;
    logic             cnt_clear;

    logic [CNT_W-1:0] mapped;
    logic             accept;
    logic             period_edge;
    logic             consume;
    logic [CNT_W-1:0] duty_in_use;

    // The counter only moves while a period is in progress; IDLE parks it at 0
    // so the first RUN cycle is always a period start.
    assign cnt_run   = (state_q != IDLE);
    assign cnt_clear = (state_q == IDLE);

    pwm_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (cnt_run),
        .clear   (cnt_clear),
        .count   (count),
        .at_zero (at_zero),
        .at_max  (at_max)
    );

    // Samples are stored already mapped to a duty value.
    assign mapped      = CNT_W'(duty_map(data_in, CNT_W));
    assign accept      = data_valid & ready_q;
    assign period_edge = (state_q == RUN) & at_zero;
    assign consume     = period_edge & hold_full_q;
    // At a period start the held duty is already the one in force for this slot.
    assign duty_in_use = consume ? hold_q : duty_q;

    // Next-state, holding register, duty register and registered output logic.
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        duty_d         = duty_q;

        unique case (state_q)
            IDLE: begin
                if (enable && hold_full_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Dropping enable on the last slot ends the period right here.
                if (!enable) begin
                    state_d = at_max ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (at_max) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Consume before accept so a same-cycle transfer refills the hold.
        if (consume) begin
            duty_d      = hold_q;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = mapped;
            hold_full_d = 1'b1;
        end

        pwm_d          = (state_q != IDLE) && (count < duty_in_use);
        period_start_d = period_edge;
        underrun_d     = period_edge & ~hold_full_q;
        busy_d         = (state_d != IDLE);
        ready_d        = ~hold_full_d & (state_d != DRAIN);
    end

    // FSM state, holding register, duty and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            duty_q         <= '0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
            busy_q         <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            duty_q         <= duty_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
        end
    end

    assign data_ready   = ready_q;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pwm_encoder.sv
// Self-checking bench for pwm_encoder (CNT_W=8). A reference model works per
// PWM period: accepted samples queue up as expected duties, each observed
// period start pops one (or expects an underrun), and every period is checked
// for length, high count, shape and handshake behaviour.
module tb_pwm_encoder;

    localparam int CNT_W  = 8;
    localparam int PERIOD = 1 << CNT_W;
    localparam int SCALE  = 65536 / PERIOD;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        pwm_out;
    logic        period_start;
    logic        underrun;
    logic        busy;

    pwm_encoder #(
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun),
        .busy         (busy)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int               checks;
    int               failures;
    logic [CNT_W-1:0] exp_q[$];
    int               hist_q[$];
    logic             active;
    int               pos;
    int               per_high;
    int               shape_err;
    int               stray;
    int               ur_seen;
    int               starts_seen;
    int               last_acc_pos;
    logic [CNT_W-1:0] cur_duty;
    logic             exp_ur;

    // Expected duty from the sample value itself: shift the signed range up to
    // 0..65535 and keep the top CNT_W bits.
    function automatic logic [CNT_W-1:0] exp_duty(input logic [15:0] s);
        int v;
        v = int'($signed(s)) + 32768;
        return CNT_W'(v / SCALE);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic close_period();
        check("period_len", 32'(pos), 32'(PERIOD));
        check("high_count", 32'(per_high), 32'(cur_duty));
        check("pwm_shape", 32'(shape_err), 32'd0);
        check("protocol", 32'(stray), 32'd0);
        hist_q.push_back(per_high);
        active    = 1'b0;
        pos       = 0;
        per_high  = 0;
        shape_err = 0;
        stray     = 0;
    endtask

    // One clock: note a transfer, advance, then observe the registered outputs.
    task automatic step();
        logic        acc;
        logic [15:0] acc_data;
        acc      = (data_valid === 1'b1) && (data_ready === 1'b1);
        acc_data = data_in;
        if (acc) last_acc_pos = pos;
        @(posedge clock);
        #1;
        if (period_start === 1'b1) begin
            if (active) close_period();
            active = 1'b1;
            starts_seen++;
            if (exp_q.size() > 0) begin
                cur_duty = exp_q.pop_front();
                exp_ur   = 1'b0;
            end else begin
                exp_ur   = 1'b1;
            end
            check("underrun", 32'(underrun), 32'(exp_ur));
            if (underrun === 1'b1) ur_seen++;
        end else if (underrun !== 1'b0) begin
            stray++;
        end
        if (active) begin
            if (pwm_out !== ((pos < int'(cur_duty)) ? 1'b1 : 1'b0)) shape_err++;
            if (pwm_out === 1'b1) per_high++;
            pos++;
            if (busy === 1'b0) close_period();
        end else if (pwm_out !== 1'b0) begin
            stray++;
        end
        if (acc) exp_q.push_back(exp_duty(acc_data));
        if (exp_q.size() > 0 && data_ready !== 1'b0) stray++;
    endtask

    task automatic send(input logic [15:0] s);
        logic got;
        int   k;
        got        = 1'b0;
        k          = 0;
        data_valid = 1'b1;
        data_in    = s;
        while (!got && k < 600) begin
            got = (data_ready === 1'b1);
            step();
            k++;
        end
        data_valid = 1'b0;
        check("send_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_starts(input int n);
        int target;
        int k;
        target = starts_seen + n;
        k      = 0;
        while (starts_seen < target && k < n * 300 + 300) begin
            step();
            k++;
        end
        check("wait_starts_done", 32'(starts_seen >= target), 32'd1);
    endtask

    task automatic wait_pos(input int p);
        int k;
        k = 0;
        while (!(active && pos == p) && k < 600) begin
            step();
            k++;
        end
        check("wait_pos_done", 32'(active && pos == p), 32'd1);
    endtask

    task automatic wait_busy_low();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 600) begin
            step();
            k++;
        end
        check("wait_idle_done", 32'(busy), 32'd0);
    endtask

    logic [15:0] smp_a, smp_b, smp_c, smp_d;
    int          ur_before;
    logic [15:0] edge_tbl[4];

    initial begin
        checks = 0; failures = 0; active = 1'b0; pos = 0; per_high = 0;
        shape_err = 0; stray = 0; ur_seen = 0; starts_seen = 0;
        last_acc_pos = -1; cur_duty = '0; exp_ur = 1'b0;
        edge_tbl[0] = 16'h8000; edge_tbl[1] = 16'h7FFF;
        edge_tbl[2] = 16'h0000; edge_tbl[3] = 16'hFFFF;

        // Reset values.
        reset_n = 1'b0; enable = 1'b0; data_valid = 1'b0; data_in = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        #2 reset_n = 1'b1;
        step();
        check("idle_ready", 32'(data_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // 50% duty back-to-back, then extremes, then repeated duty with underruns.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h0000);
        send(16'h8000);
        send(16'h7FFF);
        send(16'h4000);
        ur_before = ur_seen;
        wait_starts(4);
        check("underrun_count", 32'(ur_seen - ur_before), 32'd3);
        check("p1_high", 32'(hist_q[0]), 32'd128);
        check("p4_high", 32'(hist_q[3]), 32'd128);
        check("min_sample_high", 32'(hist_q[4]), 32'd0);
        check("max_sample_high", 32'(hist_q[5]), 32'd255);
        check("q_sample_high", 32'(hist_q[6]), 32'd192);
        check("repeat_high", 32'(hist_q[8]), 32'd192);

        // Pending sample plus a mid-period offer: no change until the wrap.
        smp_a = 16'($urandom);
        smp_b = 16'($urandom);
        send(smp_a);
        wait_pos(100);
        check("ready_low_midperiod", 32'(data_ready), 32'd0);
        send(smp_b);
        check("accept_after_wrap", 32'(last_acc_pos), 32'd1);
        check("period_unchanged", 32'(hist_q[9]), 32'd192);

        // Enable drop drains the period; re-raise in DRAIN keeps the waveform.
        wait_pos(49);
        enable = 1'b0;
        wait_busy_low();
        check("drain_pwm_low", 32'(pwm_out), 32'd0);
        check("drain_ready_held", 32'(data_ready), 32'd0);
        check("new_duty_at_wrap", 32'(hist_q[10]), 32'(exp_duty(smp_a)));
        repeat (5) step();
        check("idle_stays", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_starts(1);
        wait_pos(49);
        enable = 1'b0;
        wait_pos(199);
        check("drain_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        wait_starts(1);
        check("resume_underrun", 32'(underrun), 32'd1);
        check("resume_prev_high", 32'(hist_q[11]), 32'(exp_duty(smp_b)));

        // Asynchronous reset mid-period with the hold full.
        smp_c = 16'($urandom);
        send(smp_c);
        wait_pos(76);
        #3 reset_n = 1'b0;
        #1;
        check("arst_pwm_out", 32'(pwm_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_period_start", 32'(period_start), 32'd0);
        check("arst_underrun", 32'(underrun), 32'd0);
        check("arst_data_ready", 32'(data_ready), 32'd0);
        exp_q.delete();
        active = 1'b0; pos = 0; per_high = 0; shape_err = 0; stray = 0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (3) step();
        check("arst_hold_discarded", 32'(busy), 32'd0);
        check("arst_ready_after", 32'(data_ready), 32'd1);
        smp_d = 16'($urandom);
        send(smp_d);
        wait_starts(2);
        check("arst_first_high", 32'(hist_q[hist_q.size() - 1]), 32'(exp_duty(smp_d)));

        // Randomised traffic with gaps and enable pauses.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 400)) step();
                enable = 1'b1;
            end else begin
                repeat ($urandom_range(0, 300)) step();
            end
            if ($urandom_range(0, 3) == 0) send(edge_tbl[$urandom_range(0, 3)]);
            else                           send(16'($urandom));
        end
        wait_starts(2);
        check("protocol_final", 32'(stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
